// File: rtl/mem_request_ctrl_if.sv
// mem_request_ctrl_if: bundles the pipeline-side request and cache-side
// handshake signals of mem_request_ctrl.
//   master : controller view (takes EX/MEM request + cache response,
//            drives cache request, MEM/WB load data and stall/done status)
//   slave  : environment view (pipeline + cache), directions mirrored
// Parameter STALL_CNT_W must match the controller's STALL_CNT_W.
interface mem_request_ctrl_if #(
   parameter int unsigned STALL_CNT_W = 16
) ();

   // pipeline request (EX/MEM register)
   logic                   dRENIN;
   logic                   dWENIN;
   logic [31:0]            addrIN;
   logic [31:0]            storeIN;

   // cache response
   logic                   dhit;
   logic [31:0]            dmemload;

   // cache request
   logic                   dmemREN;
   logic                   dmemWEN;
   logic [31:0]            dmemaddr;
   logic [31:0]            dmemstore;

   // pipeline status / results
   logic [31:0]            loadOUT;
   logic                   mem_stall;
   logic                   mem_done;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      input  dRENIN, dWENIN, addrIN, storeIN, dhit, dmemload,
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      output loadOUT, mem_stall, mem_done, stall_cnt
   );

   modport slave (
      output dRENIN, dWENIN, addrIN, storeIN, dhit, dmemload,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  loadOUT, mem_stall, mem_done, stall_cnt
   );

endinterface

// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl: sequences one data-cache access per EX/MEM load/store
// request (IDLE -> REQ -> DONE) and stalls the upstream pipeline meanwhile.
// Ports:
//   CLK        system clock, rising edge
//   nRST       asynchronous active-low reset
//   bus        mem_request_ctrl_if.master
//              in : dRENIN, dWENIN, addrIN, storeIN, dhit, dmemload
//              out: dmemREN, dmemWEN, dmemaddr, dmemstore, loadOUT,
//                   mem_stall (combinational), mem_done, stall_cnt
// Optional feature: define MEM_STALL_CNT_EN to build a saturating stall-cycle
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module mem_request_ctrl #(
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                CLK,
   input  logic                nRST,
   mem_request_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        ren_q,   ren_d;
   logic        wen_q,   wen_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] store_q, store_d;
   logic [31:0] load_q,  load_d;
   logic        done_q,  done_d;

   logic        req_c;
   logic        mem_stall_c;
   logic        unused_addr_lsb;

   assign req_c           = bus.dRENIN | bus.dWENIN;
   // Byte offset is dropped: the cache is word addressed.
   assign unused_addr_lsb = ^bus.addrIN[1:0];

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_c)    next_state = REQ;
         REQ:     if (bus.dhit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      ren_d   = ren_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      store_d = store_q;
      load_d  = load_q;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (req_c) begin
               // A simultaneous read and write performs the read only.
               ren_d   = bus.dRENIN;
               wen_d   = bus.dWENIN & ~bus.dRENIN;
               addr_d  = {bus.addrIN[31:2], 2'b00};
               store_d = bus.storeIN;
            end
         end
         REQ: begin
            if (bus.dhit) begin
               ren_d  = 1'b0;
               wen_d  = 1'b0;
               done_d = 1'b1;
               if (ren_q) begin
                  load_d = bus.dmemload;
               end
            end
         end
         DONE: begin
            ren_d = 1'b0;
            wen_d = 1'b0;
         end
         default: begin
            ren_d = 1'b0;
            wen_d = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         load_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         load_q  <= load_d;
         done_q  <= done_d;
      end
   end

   // DONE releases the stall so the pipeline advances exactly once per access.
   assign mem_stall_c = req_c & (state != DONE);

   assign bus.dmemREN   = ren_q;
   assign bus.dmemWEN   = wen_q;
   assign bus.dmemaddr  = addr_q;
   assign bus.dmemstore = store_q;
   assign bus.loadOUT   = load_q;
   assign bus.mem_done  = done_q;
   assign bus.mem_stall = mem_stall_c;

`ifdef MEM_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] cnt_q;

   // Saturating stall-cycle counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= '0;
      end else if (mem_stall_c && (cnt_q != '1)) begin
         cnt_q <= cnt_q + STALL_CNT_W'(1);
      end
   end

   assign bus.stall_cnt = cnt_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_request_ctrl.sv
// tb_mem_request_ctrl: directed bench for mem_request_ctrl. Expected
// completions are queued when a request is issued; a monitor pops and
// compares them whenever the DUT pulses mem_done.
module tb_mem_request_ctrl;

   localparam int unsigned STALL_CNT_W = 4;
   localparam int unsigned CNT_MAX     = (1 << STALL_CNT_W) - 1;
`ifdef MEM_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] load;
      logic [31:0] store;
   } exp_t;

   logic CLK;
   logic nRST;

   mem_request_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

   mem_request_ctrl #(.STALL_CNT_W(STALL_CNT_W)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   exp_t        exp_q[$];
   exp_t        sb_e;
   int          sb_pass;
   int          sb_fail;
   int          dir_pass;
   int          dir_fail;
   logic [31:0] exp_load;
   int unsigned total_stall;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Scoreboard monitor: one expected completion per mem_done pulse
   always @(negedge CLK) begin
      if (nRST && bus.mem_done) begin
         if (exp_q.size() == 0) begin
            sb_fail++;
            $display("FAIL sb_unexpected_done: got mem_done=1 required no completion");
         end else begin
            sb_e = exp_q.pop_front();
            if (bus.dmemaddr == sb_e.addr && bus.loadOUT == sb_e.load &&
                bus.dmemstore == sb_e.store) begin
               sb_pass++;
            end else begin
               sb_fail++;
               $display("FAIL sb_done: got addr=%h load=%h store=%h required addr=%h load=%h store=%h",
                        bus.dmemaddr, bus.loadOUT, bus.dmemstore,
                        sb_e.addr, sb_e.load, sb_e.store);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act === req) begin
         dir_pass++;
      end else begin
         dir_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int unsigned n);
      if (!CNT_EN) return 32'd0;
      return (n > CNT_MAX) ? 32'(CNT_MAX) : 32'(n);
   endfunction

   task automatic zero_checks(input string tag);
      check({tag, "_ren"},   32'(bus.dmemREN),   32'd0);
      check({tag, "_wen"},   32'(bus.dmemWEN),   32'd0);
      check({tag, "_addr"},  bus.dmemaddr,       32'd0);
      check({tag, "_store"}, bus.dmemstore,      32'd0);
      check({tag, "_load"},  bus.loadOUT,        32'd0);
      check({tag, "_done"},  32'(bus.mem_done),  32'd0);
      check({tag, "_cnt"},   32'(bus.stall_cnt), 32'd0);
   endtask

   task automatic drive_idle();
      bus.dRENIN   = 1'b0;
      bus.dWENIN   = 1'b0;
      bus.addrIN   = '0;
      bus.storeIN  = '0;
      bus.dhit     = 1'b0;
      bus.dmemload = '0;
   endtask

   // Pulse reset away from the clock edge; outputs must clear immediately.
   task automatic do_reset(input string tag);
      @(negedge CLK);
      nRST = 1'b0;
      drive_idle();
      #1;
      zero_checks(tag);
      @(negedge CLK);
      nRST        = 1'b1;
      exp_load    = '0;
      total_stall = 0;
   endtask

   // Drives one access starting at a negedge, answers dhit in REQ cycle
   // 'hit', and returns at the negedge of the following IDLE cycle with the
   // request still asserted (the pipeline has not yet presented a new one).
   task automatic access(input string tag, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] store,
                         input logic [31:0] rdata, input int hit);
      int          stall_n;
      int          ren_n;
      int          wen_n;
      int          req_n;
      bit          first_idle;
      bit          stable;
      bit          done;
      logic [31:0] waddr;
      waddr    = {addr[31:2], 2'b00};
      if (ren) exp_load = rdata;
      exp_q.push_back('{addr: waddr, load: exp_load, store: store});
      bus.dRENIN  = ren;
      bus.dWENIN  = wen;
      bus.addrIN  = addr;
      bus.storeIN = store;
      stall_n = 0; ren_n = 0; wen_n = 0; req_n = 0;
      first_idle = 1'b0; stable = 1'b1; done = 1'b0;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (c == 0) first_idle = !bus.dmemREN && !bus.dmemWEN && bus.mem_stall;
         if (bus.mem_stall) stall_n++;
         if (bus.dmemREN) ren_n++;
         if (bus.dmemWEN) wen_n++;
         if (bus.dmemREN || bus.dmemWEN) begin
            req_n++;
            if (bus.dmemaddr != waddr || bus.dmemstore != store) stable = 1'b0;
            if (req_n == hit) begin
               bus.dhit     = 1'b1;
               bus.dmemload = rdata;
            end
         end
         if (bus.mem_done) begin
            done = 1'b1;
            break;
         end
         @(negedge CLK);
         bus.dhit     = 1'b0;
         bus.dmemload = ~rdata;
      end
      check({tag, "_completed"},  32'(done),       32'd1);
      check({tag, "_idle_first"}, 32'(first_idle), 32'd1);
      check({tag, "_stable"},     32'(stable),     32'd1);
      check({tag, "_stall"},      32'(stall_n),    32'(hit + 1));
      check({tag, "_ren_cyc"},    32'(ren_n),      ren ? 32'(hit) : 32'd0);
      check({tag, "_wen_cyc"},    32'(wen_n),      (wen && !ren) ? 32'(hit) : 32'd0);
      @(negedge CLK);
      total_stall += 32'(hit + 1);
      check({tag, "_stall_cnt"},  32'(bus.stall_cnt), exp_cnt(total_stall));
   endtask

   initial begin
      int done_n;
      sb_pass = 0; sb_fail = 0; dir_pass = 0; dir_fail = 0;
      exp_load = '0; total_stall = 0;
      nRST = 1'b1;
      drive_idle();
      #2;
      do_reset("rst0");

      // Load with immediate hit, unaligned byte address
      access("load_fast", 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'hDEAD_BEEF, 1);
      // Store with hit in the 5th REQ cycle; loadOUT must keep the last load
      access("store_slow", 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_0000, 5);
      check("store_load_kept", bus.loadOUT, 32'hDEAD_BEEF);
      // Read and write together: read only
      access("rw_both", 1'b1, 1'b1, 32'h0000_0009, 32'hAAAA_5555, 32'h0BAD_F00D, 2);
      // Back-to-back loads: request held through DONE must wait for IDLE
      access("b2b_1", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_1111, 1);
      access("b2b_2", 1'b1, 1'b0, 32'h0000_0206, 32'h0, 32'h2222_2222, 1);
      check("b2b_load_last", bus.loadOUT, 32'h2222_2222);

      // Reset in the middle of a request, then a stray dhit
      bus.dRENIN = 1'b1;
      bus.dWENIN = 1'b0;
      bus.addrIN = 32'h0000_0300;
      @(negedge CLK);
      check("rstmid_req_issued", 32'(bus.dmemREN), 32'd1);
      nRST = 1'b0;
      bus.dRENIN = 1'b0;
      #1;
      zero_checks("rstmid");
      check("rstmid_stall", 32'(bus.mem_stall), 32'd0);
      @(negedge CLK);
      nRST         = 1'b1;
      exp_load     = '0;
      total_stall  = 0;
      bus.dhit     = 1'b1;
      bus.dmemload = 32'hCAFE_F00D;
      @(negedge CLK);
      bus.dhit = 1'b0;
      done_n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (bus.mem_done) done_n++;
      end
      check("rstmid_no_done", 32'(done_n),       32'd0);
      check("rstmid_load",    bus.loadOUT,       32'd0);
      check("rstmid_ren",     32'(bus.dmemREN),  32'd0);
      check("rstmid_cnt",     32'(bus.stall_cnt), 32'd0);

      // Long access: stall counter saturates
      do_reset("rst1");
      access("sat", 1'b1, 1'b0, 32'h0000_07FC, 32'h0, 32'h5A5A_5A5A, 19);
      bus.dRENIN = 1'b0;
      @(negedge CLK);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", sb_pass + dir_pass,
               sb_pass + dir_pass + sb_fail + dir_fail);
      $finish;
   end

endmodule
